uart_tx: RTL and testbench

- Serial UART transmitter; the transmit-side counterpart of the team's receiver.
- Accepts one parallel word through a ready/start handshake and serialises it on o_tx.
- Frame: start bit, NB_DATA data bits LSB first, optional parity bit, 1 or 2 stop bits.
- Bit timing comes from the shared baud-tick generator through i_baud_tick; this block only counts ticks.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/uart_tx.sv | 128 ++++++++++++
 tb/tb_uart_tx.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity mode constants.
// Used by both the transmitter and the receiver so that both encode state and parity the same way.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    // Mode 2'b11 is not a parity mode and behaves like PAR_NONE.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: start, NB_DATA bits LSB first, optional parity, NB_STOP stop bits, timed by i_baud_tick.
// o_tx goes low 1 clk after acceptance; a start is only taken while o_tx_ready is high, otherwise dropped.
module uart_tx
    import uart_pkg::*;
#(
    parameter int         NB_DATA       = 8,
    parameter logic [1:0] PARITY_MODE   = 2'b00,
    parameter int         NB_STOP       = 1,
    parameter int         TICKS_PER_BIT = 16
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_baud_tick,
    input  logic               i_tx_start,
    input  logic [NB_DATA-1:0] i_tx_data,
    output logic               o_tx,
    output logic               o_tx_ready,
    output logic               o_tx_busy,
    output logic               o_tx_done
);

    localparam int             TW         = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICKS_PER_BIT - 1);
    localparam logic [3:0]     DATA_LAST  = 4'(NB_DATA - 1);
    localparam logic [3:0]     STOP_LAST  = 4'(NB_STOP - 1);
    localparam logic           USE_PARITY = parity_enabled(PARITY_MODE);

    state_t             state_q, state_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [3:0]         bit_q, bit_d;
    logic [NB_DATA-1:0] shift_q, shift_d;
    logic               par_q, par_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;
    logic               period_end;

    assign period_end = i_baud_tick && (tick_q == TICK_LAST);

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        done_d  = 1'b0;
        tx_d    = 1'b1;

        // Ticks only count while a frame is in flight; the acceptance-cycle tick is dropped.
        if (state_q != IDLE && i_baud_tick) begin
            tick_d = period_end ? '0 : tick_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (i_tx_start) begin
                    state_d = START;
                    tick_d  = '0;
                    bit_d   = '0;
                    shift_d = i_tx_data;
                    par_d   = (^i_tx_data) ^ (PARITY_MODE == PAR_ODD);
                end
            end
            START: begin
                if (period_end) state_d = DATA;
            end
            DATA: begin
                if (period_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = USE_PARITY ? PARITY : STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (period_end) state_d = STOP;
            end
            STOP: begin
                if (period_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d   = '0;
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is registered from the next state so o_tx never glitches.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_q;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    assign o_tx       = tx_q;
    assign o_tx_ready = (state_q == IDLE);
    assign o_tx_busy  = !o_tx_ready;
    assign o_tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Four uart_tx configurations driven with random traffic; a tick-counting frame model checks the
// line every cycle and a mid-bit sampling receiver decodes each frame against the sent words.
module tb_uart_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic baud_tick = 1'b0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int cfg_nb(input int g);
        case (g) 0: return 8; 1: return 8; 2: return 5; default: return 9; endcase
    endfunction
    function automatic logic [1:0] cfg_pm(input int g);
        case (g) 0: return 2'b00; 1: return 2'b01; 2: return 2'b10; default: return 2'b11; endcase
    endfunction
    function automatic int cfg_stop(input int g);
        case (g) 0: return 1; 1: return 2; 2: return 1; default: return 2; endcase
    endfunction
    function automatic int cfg_t(input int g);
        case (g) 0: return 16; 1: return 4; 2: return 1; default: return 3; endcase
    endfunction

    function automatic bit par_of(input bit [8:0] w, input bit odd);
        return (($countones(w) % 2) == 1) ^ odd;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1 baud_tick = ($urandom_range(0, 7) != 0);
        end
    end

    for (genvar g = 0; g < 4; g++) begin : gi
        localparam int         NB     = cfg_nb(g);
        localparam logic [1:0] PM     = cfg_pm(g);
        localparam int         NS     = cfg_stop(g);
        localparam int         T      = cfg_t(g);
        localparam int         HASP   = (PM == 2'b01 || PM == 2'b10) ? 1 : 0;
        localparam int         L      = 1 + NB + HASP + NS;
        localparam int         TARGET = (g == 0) ? 256 : 150;

        logic       rst = 1'b0;
        logic       start = 1'b0;
        logic [8:0] data = '0;
        logic       tx, ready, busy, done;

        uart_tx #(
            .NB_DATA      (NB),
            .PARITY_MODE  (PM),
            .NB_STOP      (NS),
            .TICKS_PER_BIT(T)
        ) dut (
            .clk        (clk),
            .i_rst      (rst),
            .i_baud_tick(baud_tick),
            .i_tx_start (start),
            .i_tx_data  (data[NB-1:0]),
            .o_tx       (tx),
            .o_tx_ready (ready),
            .o_tx_busy  (busy),
            .o_tx_done  (done)
        );

        bit       active = 0, done_exp = 0, tick_s = 0, fin = 0;
        int       n = 0;
        bit       fb[16];
        bit [8:0] sent_q[$];
        bit [8:0] dir_q[$];
        bit       rx_on = 0;
        int       rx_cnt = 0, rx_k = 0, rx_frames = 0;
        bit [8:0] rx_word = '0;

        task automatic abandon();
            if (active && sent_q.size() > 0) void'(sent_q.pop_back());
            active   = 0;
            done_exp = 0;
            rx_on    = 0;
        endtask

        // Reference: after acceptance the line shows frame bit floor(ticks/T); done when ticks reach L*T.
        initial begin
            bit [8:0] d;
            int       exp_w;
            forever begin
                @(posedge clk);
                tick_s   = baud_tick;
                done_exp = 0;
                if (rst) begin
                    abandon();
                end else if (!active) begin
                    if (start) begin
                        d = data;
                        for (int i = NB; i < 9; i++) d[i] = 1'b0;
                        fb[0] = 1'b0;
                        for (int i = 0; i < NB; i++) fb[1 + i] = d[i];
                        if (HASP == 1) fb[1 + NB] = par_of(d, PM == 2'b10);
                        for (int s = 0; s < NS; s++) fb[1 + NB + HASP + s] = 1'b1;
                        n      = 0;
                        active = 1;
                        sent_q.push_back(d);
                        if (dir_q.size() > 0 && dir_q[0] == d) void'(dir_q.pop_front());
                    end
                end else if (tick_s) begin
                    n++;
                    if (n == L * T) begin
                        active   = 0;
                        done_exp = 1;
                    end
                end
                if (rx_on && tick_s && !rst) rx_cnt++;

                @(negedge clk);
                if (rst) abandon();
                chk($sformatf("g%0d_line{tx,rdy,busy,done}", g), {28'd0, tx, ready, busy, done},
                    {28'd0, (active ? fb[n / T] : 1'b1), !active, active, done_exp});

                if (!rx_on) begin
                    if (!rst && tx == 1'b0) begin
                        rx_on = 1; rx_cnt = 0; rx_k = 1; rx_word = '0;
                    end
                end else if (tick_s && rx_cnt == rx_k * T + T / 2) begin
                    if (rx_k <= NB) begin
                        rx_word[rx_k - 1] = tx;
                    end else if (HASP == 1 && rx_k == NB + 1) begin
                        chk($sformatf("g%0d_rx_parity", g), {31'd0, tx},
                            {31'd0, (sent_q.size() > 0) ? par_of(sent_q[0], PM == 2'b10) : ~tx});
                    end else begin
                        chk($sformatf("g%0d_rx_stop", g), {31'd0, tx}, 32'd1);
                    end
                    if (rx_k == L - 1) begin
                        exp_w = (sent_q.size() > 0) ? int'(sent_q.pop_front()) : 32'h3FF;
                        chk($sformatf("g%0d_rx_word", g), {23'd0, rx_word}, exp_w);
                        rx_on = 0;
                        rx_frames++;
                    end
                    rx_k++;
                end
            end
        end

        initial begin
            bit b2b      = (g == 0);
            bit rst_done = (g != 0);
            if (g == 0) dir_q.push_back(9'h055);
            if (g == 1) begin dir_q.push_back(9'h007); dir_q.push_back(9'h0A3); end
            if (g == 2) dir_q.push_back(9'h007);
            #2 rst = 1'b1;
            #1 chk($sformatf("g%0d_reset_state", g), {28'd0, tx, ready, busy, done}, 32'hC);
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            while (rx_frames < TARGET) begin
                if (!rst_done && rx_frames >= 5 && active && (n / T) == 5) begin
                    start = 1'b0;
                    #1 rst = 1'b1;
                    #1 chk("g0_reset_midframe", {28'd0, tx, ready, busy, done}, 32'hC);
                    repeat (2) @(posedge clk);
                    #1 rst = 1'b0;
                    rst_done = 1;
                    dir_q.push_back(9'h081);
                end else if (b2b && done_exp) begin
                    start = 1'b1;
                    data  = 9'h03C;
                    b2b   = 0;
                end else if (dir_q.size() > 0) begin
                    start = !active;
                    data  = dir_q[0];
                end else begin
                    start = ($urandom_range(0, 3) == 0);
                    data  = 9'($urandom);
                end
                @(posedge clk);
                #1;
            end
            start = 1'b0;
            fin   = 1;
        end
    end

    initial begin
        int cyc = 0;
        while (cyc < 90000 && !(gi[0].fin && gi[1].fin && gi[2].fin && gi[3].fin)) begin
            @(posedge clk);
            cyc++;
        end
        chk("all_configs_finished", {28'd0, gi[3].fin, gi[2].fin, gi[1].fin, gi[0].fin}, 32'hF);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
